// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit controller: holding register, LSB-first serializer, parity and
// 1/2 stop bits in one FSM. CLK is the baud clock, so one cycle is one bit.
module uart_tx_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  par_en;
      logic                  par_typ;
      logic                  stop2;
   } frame_cfg_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_t           state, state_nxt;
   frame_cfg_t       cfg, cfg_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             final_stop, accept;
   logic             tx_nxt, busy_nxt, done_nxt;

   always_comb begin
      state_nxt  = state;
      cfg_nxt    = cfg;
      cnt_nxt    = cnt;
      final_stop = (state == S_STOP1 && !cfg.stop2) || state == S_STOP2;
      accept     = Data_Valid && (state == S_IDLE || final_stop);

      case (state)
         S_IDLE:   state_nxt = S_IDLE;
         S_START:  state_nxt = S_DATA;
         S_DATA: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_BIT)
               state_nxt = cfg.par_en ? S_PARITY : S_STOP1;
         end
         S_PARITY: state_nxt = S_STOP1;
         S_STOP1:  state_nxt = cfg.stop2 ? S_STOP2 : S_IDLE;
         S_STOP2:  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase

      // Accepting in the final stop cycle chains the next start bit with no idle gap
      if (accept) begin
         state_nxt       = S_START;
         cfg_nxt.data    = P_DATA;
         cfg_nxt.par_en  = PAR_EN;
         cfg_nxt.par_typ = PAR_TYP;
         cfg_nxt.stop2   = STOP2;
         cnt_nxt         = '0;
      end

      // Outputs are decoded from the next state so they register alongside it
      tx_nxt = 1'b1;
      case (state_nxt)
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = cfg_nxt.data[cnt_nxt];
         S_PARITY: tx_nxt = (^cfg_nxt.data) ^ cfg_nxt.par_typ;
         default:  tx_nxt = 1'b1;
      endcase
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_STOP1 && !cfg_nxt.stop2) || state_nxt == S_STOP2;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         cfg        <= '0;
         cnt        <= '0;
         TX_OUT     <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cfg        <= cfg_nxt;
         cnt        <= cnt_nxt;
         TX_OUT     <= tx_nxt;
         busy       <= busy_nxt;
         frame_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
module tb_uart_tx_frame_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [8:0] pdat;
   logic       dv, par_en, par_typ, stop2;
   logic       stim_done = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 8 : (g == 1) ? 5 : 9;
      logic       tx, bsy, fd;
      logic [2:0] q[$];
      logic [2:0] exp_v;
      int         ones;

      uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
         .CLK(CLK), .RST(RST), .P_DATA(pdat[W-1:0]), .Data_Valid(dv),
         .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
         .TX_OUT(tx), .busy(bsy), .frame_done(fd)
      );

      always @(posedge CLK) begin
         if (RST) q.delete();
         else if (dv && q.size() == 0) begin
            ones = 0;
            q.push_back(3'b010);
            for (int i = 0; i < W; i++) begin
               q.push_back({pdat[i], 2'b10});
               ones += int'(pdat[i]);
            end
            if (par_en) q.push_back({((ones % 2) == 1) ^ par_typ, 2'b10});
            if (stop2) q.push_back(3'b110);
            q.push_back(3'b111);
         end
      end

      always @(posedge CLK) begin
         #1;
         exp_v = (q.size() != 0) ? q.pop_front() : 3'b100;
         checks++;
         if ({tx, bsy, fd} !== exp_v) begin
            errors++;
            $display("FAIL w%0d cyc %0d tx/busy/done got %b exp %b", W, cyc, {tx, bsy, fd}, exp_v);
         end
      end
   end

   task automatic chk(input logic [2:0] got, input logic [2:0] exp_v, input string tag);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s cyc %0d tx/busy/done got %b exp %b", tag, cyc, got, exp_v);
      end
   endtask

   task automatic randomize_inputs();
      pdat    = 9'($urandom);
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
      stop2   = 1'($urandom);
   endtask

   task automatic send(input logic [8:0] d, input logic e, input logic t,
                       input logic s, input int gap);
      pdat = d; par_en = e; par_typ = t; stop2 = s; dv = 1'b1;
      @(negedge CLK);
      dv = 1'b0;
      randomize_inputs();
      repeat (gap) @(negedge CLK);
   endtask

   initial begin
      #100000;
      if (!stim_done) begin
         errors++;
         $display("FAIL timeout: stimulus did not complete, cyc %0d", cyc);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      RST = 1'b1;
      dv  = 1'($urandom);
      randomize_inputs();
      repeat (2) begin
         @(negedge CLK);
         chk({g_dut[0].tx, g_dut[0].bsy, g_dut[0].fd}, 3'b100, "reset w8");
         chk({g_dut[1].tx, g_dut[1].bsy, g_dut[1].fd}, 3'b100, "reset w5");
         chk({g_dut[2].tx, g_dut[2].bsy, g_dut[2].fd}, 3'b100, "reset w9");
         dv = 1'($urandom);
         randomize_inputs();
      end
      RST = 1'b0;
      dv  = 1'b0;
      repeat (5) @(negedge CLK);

      send(9'h0A5, 1'b1, 1'b0, 1'b0, 14);
      send(9'h0A5, 1'b1, 1'b1, 1'b1, 14);
      send(9'h0A5, 1'b0, 1'b0, 1'b0, 14);

      pdat = 9'h001; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
      repeat (9) @(negedge CLK);
      pdat = 9'h0FF;
      repeat (14) @(negedge CLK);
      dv = 1'b0;
      repeat (15) @(negedge CLK);

      send(9'h05A, 1'b1, 1'b0, 1'b0, 4);
      send(9'h1C3, 1'b0, 1'b1, 1'b1, 14);

      send(9'h03C, 1'b1, 1'b0, 1'b1, 4);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      send(9'h1B7, 1'b1, 1'b1, 1'b0, 15);

      repeat (400) begin
         dv = ($urandom_range(0, 3) == 0);
         randomize_inputs();
         @(negedge CLK);
      end
      dv = 1'b0;
      repeat (20) @(negedge CLK);

      stim_done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
